// File: rtl/s_axis_cc_adapt_gen_if.sv
// Bundles the LitePCIe-side (_a) and hard-IP-side CC AXI-Stream signals of the adapter.
// slave = adapter view, master = upstream/downstream environment view.
interface s_axis_cc_adapt_gen_if #(
  parameter int DATA_WIDTH = 128,
  parameter int KEEP_WIDTH = DATA_WIDTH/8,
  parameter int TUSER_W    = 33
);
  logic [DATA_WIDTH-1:0]    s_axis_cc_tdata_a;
  logic [KEEP_WIDTH-1:0]    s_axis_cc_tkeep_a;
  logic                     s_axis_cc_tlast_a;
  logic [3:0]               s_axis_cc_tuser_a;
  logic                     s_axis_cc_tvalid_a;
  logic                     s_axis_cc_tready_a;
  logic [DATA_WIDTH-1:0]    s_axis_cc_tdata;
  logic [DATA_WIDTH/32-1:0] s_axis_cc_tkeep;
  logic                     s_axis_cc_tlast;
  logic [TUSER_W-1:0]       s_axis_cc_tuser;
  logic                     s_axis_cc_tvalid;
  logic [3:0]               s_axis_cc_tready;

  modport slave (
    input  s_axis_cc_tdata_a, s_axis_cc_tkeep_a, s_axis_cc_tlast_a, s_axis_cc_tuser_a,
           s_axis_cc_tvalid_a, s_axis_cc_tready,
    output s_axis_cc_tready_a, s_axis_cc_tdata, s_axis_cc_tkeep, s_axis_cc_tlast,
           s_axis_cc_tuser, s_axis_cc_tvalid
  );

  modport master (
    output s_axis_cc_tdata_a, s_axis_cc_tkeep_a, s_axis_cc_tlast_a, s_axis_cc_tuser_a,
           s_axis_cc_tvalid_a, s_axis_cc_tready,
    input  s_axis_cc_tready_a, s_axis_cc_tdata, s_axis_cc_tkeep, s_axis_cc_tlast,
           s_axis_cc_tuser, s_axis_cc_tvalid
  );
endinterface

// File: rtl/s_axis_cc_adapt_gen.sv
// LitePCIe completion TLP -> UltraScale(+) CC descriptor adapter, 64..512-bit datapaths.
// One registered output stage; the 64-bit path reassembles the 3DW header across two beats.
module s_axis_cc_adapt_gen #(
  parameter int DATA_WIDTH = 128,
  parameter int KEEP_WIDTH = DATA_WIDTH/8,
  parameter int TUSER_W    = 33
) (
  input  logic                  user_clk,
  input  logic                  user_reset_n,
  s_axis_cc_adapt_gen_if.slave  cc
);
  localparam int DW_N = DATA_WIDTH/32;

  typedef enum logic [1:0] {HDR1, HDR2, FLUSH, BODY} state_t;
  state_t state, state_nxt;

  logic                  load_p0;
  logic [DATA_WIDTH-1:0] nxt_data, data_p0;
  logic [DW_N-1:0]       nxt_keep, keep_p0, keep_a;
  logic                  nxt_last, last_p0, nxt_disc, disc_p0, vld_p0;
  logic                  out_free, accept;
  logic [31:0]           hdr_h0, hdr_h1, hdr_h2;
  logic                  hdr_ecrc;
  logic [95:0]           desc;
  logic                  unused_bits;

  if (!(DATA_WIDTH == 64 || DATA_WIDTH == 128 || DATA_WIDTH == 256 || DATA_WIDTH == 512)) begin : g_bad_width
    $error("s_axis_cc_adapt_gen: DATA_WIDTH must be 64, 128, 256 or 512");
  end

  for (genvar i = 0; i < DW_N; i++) begin : g_keep
    assign keep_a[i] = |cc.s_axis_cc_tkeep_a[4*i +: 4];
  end

  assign out_free              = !vld_p0 || cc.s_axis_cc_tready[0];
  assign cc.s_axis_cc_tready_a = user_reset_n && (state != FLUSH) && out_free;
  assign accept                = cc.s_axis_cc_tvalid_a && cc.s_axis_cc_tready_a;

  // Header DW0..2 -> descriptor DW0..2; every bit not assigned here stays 0.
  always_comb begin
    desc          = '0;
    desc[6:0]     = hdr_h2[6:0];
    desc[28:16]   = {1'b0, hdr_h1[11:0]};
    desc[29]      = (hdr_h0[29:24] == 6'b001011);
    desc[41:32]   = hdr_h0[9:0];
    desc[45:43]   = hdr_h1[15:13];
    desc[46]      = hdr_h0[14];
    desc[63:48]   = hdr_h2[31:16];
    desc[71:64]   = hdr_h2[15:8];
    desc[87:72]   = hdr_h1[31:16];
    desc[91:89]   = hdr_h0[22:20];
    desc[94:92]   = {1'b0, hdr_h0[13:12]};
    desc[95]      = hdr_h0[15] | hdr_ecrc;
  end

  assign unused_bits = ^{hdr_h0[31:30], hdr_h0[23], hdr_h0[19:16], hdr_h0[11:10],
                         hdr_h1[12], hdr_h2[7], cc.s_axis_cc_tuser_a[2:1], cc.s_axis_cc_tready[3:1]};

  if (DATA_WIDTH == 64) begin : g_w64
    logic [63:0] hold_data, pend_data;
    logic [1:0]  pend_keep;
    logic        hold_ecrc, hold_disc, pend_last, pend_disc;

    assign hdr_h0   = hold_data[31:0];
    assign hdr_h1   = hold_data[63:32];
    assign hdr_h2   = cc.s_axis_cc_tdata_a[31:0];
    assign hdr_ecrc = hold_ecrc;

    always_comb begin
      load_p0   = 1'b0;
      nxt_data  = cc.s_axis_cc_tdata_a;
      nxt_keep  = keep_a;
      nxt_last  = cc.s_axis_cc_tlast_a;
      nxt_disc  = cc.s_axis_cc_tuser_a[3];
      state_nxt = state;
      case (state)
        HDR1: if (accept) begin
          if (cc.s_axis_cc_tlast_a) begin
            // Header cut short: report it downstream as a discontinued empty beat.
            load_p0  = 1'b1;
            nxt_data = '0;
            nxt_keep = '0;
            nxt_last = 1'b1;
            nxt_disc = 1'b1;
          end else begin
            state_nxt = HDR2;
          end
        end
        HDR2: if (accept) begin
          load_p0   = 1'b1;
          nxt_data  = desc[63:0];
          nxt_keep  = '1;
          nxt_last  = 1'b0;
          nxt_disc  = hold_disc | cc.s_axis_cc_tuser_a[3];
          state_nxt = FLUSH;
        end
        FLUSH: if (out_free) begin
          load_p0   = 1'b1;
          nxt_data  = pend_data;
          nxt_keep  = pend_keep;
          nxt_last  = pend_last;
          nxt_disc  = pend_disc;
          state_nxt = pend_last ? HDR1 : BODY;
        end
        default: if (accept) begin
          load_p0 = 1'b1;
          if (cc.s_axis_cc_tlast_a) state_nxt = HDR1;
        end
      endcase
    end

    always_ff @(posedge user_clk or negedge user_reset_n) begin
      if (!user_reset_n) begin
        hold_data <= '0;
        hold_ecrc <= 1'b0;
        hold_disc <= 1'b0;
        pend_data <= '0;
        pend_keep <= '0;
        pend_last <= 1'b0;
        pend_disc <= 1'b0;
      end else begin
        if (state == HDR1 && accept && !cc.s_axis_cc_tlast_a) begin
          hold_data <= cc.s_axis_cc_tdata_a;
          hold_ecrc <= cc.s_axis_cc_tuser_a[0];
          hold_disc <= cc.s_axis_cc_tuser_a[3];
        end
        if (state == HDR2 && accept) begin
          pend_data <= {cc.s_axis_cc_tdata_a[63:32], desc[95:64]};
          pend_keep <= {keep_a[1], 1'b1};
          pend_last <= cc.s_axis_cc_tlast_a;
          pend_disc <= hold_disc | cc.s_axis_cc_tuser_a[3];
        end
      end
    end
  end else begin : g_wide
    assign hdr_h0   = cc.s_axis_cc_tdata_a[31:0];
    assign hdr_h1   = cc.s_axis_cc_tdata_a[63:32];
    assign hdr_h2   = cc.s_axis_cc_tdata_a[95:64];
    assign hdr_ecrc = cc.s_axis_cc_tuser_a[0];

    always_comb begin
      load_p0   = accept;
      nxt_data  = cc.s_axis_cc_tdata_a;
      if (state == HDR1) nxt_data[95:0] = desc;
      nxt_keep  = keep_a;
      nxt_last  = cc.s_axis_cc_tlast_a;
      nxt_disc  = cc.s_axis_cc_tuser_a[3];
      state_nxt = state;
      if (accept) begin
        if (cc.s_axis_cc_tlast_a) state_nxt = HDR1;
        else if (state == HDR1)   state_nxt = BODY;
      end
    end
  end

  // ---- output stage p0: holds until the hard IP takes it ----
  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      state   <= HDR1;
      vld_p0  <= 1'b0;
      data_p0 <= '0;
      keep_p0 <= '0;
      last_p0 <= 1'b0;
      disc_p0 <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load_p0) begin
        vld_p0  <= 1'b1;
        data_p0 <= nxt_data;
        keep_p0 <= nxt_keep;
        last_p0 <= nxt_last;
        disc_p0 <= nxt_disc;
      end else if (cc.s_axis_cc_tready[0]) begin
        vld_p0 <= 1'b0;
      end
    end
  end

  assign cc.s_axis_cc_tvalid = vld_p0;
  assign cc.s_axis_cc_tdata  = data_p0;
  assign cc.s_axis_cc_tkeep  = keep_p0;
  assign cc.s_axis_cc_tlast  = last_p0;
  assign cc.s_axis_cc_tuser  = {{(TUSER_W-1){1'b0}}, disc_p0};
endmodule

// File: tb/tb_s_axis_cc_adapt_gen.sv
// Directed bench for the CC adapter at 64/128/256/512-bit widths with hand-computed descriptors.
module tb_s_axis_cc_adapt_gen;
  logic user_clk;
  logic user_reset_n;
  int   checks = 0;
  int   passes = 0;

  s_axis_cc_adapt_gen_if #(.DATA_WIDTH(64),  .KEEP_WIDTH(8),  .TUSER_W(33)) i64 ();
  s_axis_cc_adapt_gen_if #(.DATA_WIDTH(128), .KEEP_WIDTH(16), .TUSER_W(33)) i128 ();
  s_axis_cc_adapt_gen_if #(.DATA_WIDTH(256), .KEEP_WIDTH(32), .TUSER_W(33)) i256 ();
  s_axis_cc_adapt_gen_if #(.DATA_WIDTH(512), .KEEP_WIDTH(64), .TUSER_W(81)) i512 ();

  s_axis_cc_adapt_gen #(.DATA_WIDTH(64),  .KEEP_WIDTH(8),  .TUSER_W(33)) dut64  (.user_clk(user_clk), .user_reset_n(user_reset_n), .cc(i64));
  s_axis_cc_adapt_gen #(.DATA_WIDTH(128), .KEEP_WIDTH(16), .TUSER_W(33)) dut128 (.user_clk(user_clk), .user_reset_n(user_reset_n), .cc(i128));
  s_axis_cc_adapt_gen #(.DATA_WIDTH(256), .KEEP_WIDTH(32), .TUSER_W(33)) dut256 (.user_clk(user_clk), .user_reset_n(user_reset_n), .cc(i256));
  s_axis_cc_adapt_gen #(.DATA_WIDTH(512), .KEEP_WIDTH(64), .TUSER_W(81)) dut512 (.user_clk(user_clk), .user_reset_n(user_reset_n), .cc(i512));

  initial begin
    user_clk = 1'b0;
    forever #5 user_clk = ~user_clk;
  end

  task automatic idle_all();
    i64.s_axis_cc_tdata_a  = '0; i64.s_axis_cc_tkeep_a  = '0; i64.s_axis_cc_tlast_a  = 0; i64.s_axis_cc_tuser_a  = '0; i64.s_axis_cc_tvalid_a  = 0; i64.s_axis_cc_tready  = 4'hF;
    i128.s_axis_cc_tdata_a = '0; i128.s_axis_cc_tkeep_a = '0; i128.s_axis_cc_tlast_a = 0; i128.s_axis_cc_tuser_a = '0; i128.s_axis_cc_tvalid_a = 0; i128.s_axis_cc_tready = 4'hF;
    i256.s_axis_cc_tdata_a = '0; i256.s_axis_cc_tkeep_a = '0; i256.s_axis_cc_tlast_a = 0; i256.s_axis_cc_tuser_a = '0; i256.s_axis_cc_tvalid_a = 0; i256.s_axis_cc_tready = 4'hF;
    i512.s_axis_cc_tdata_a = '0; i512.s_axis_cc_tkeep_a = '0; i512.s_axis_cc_tlast_a = 0; i512.s_axis_cc_tuser_a = '0; i512.s_axis_cc_tvalid_a = 0; i512.s_axis_cc_tready = 4'hF;
  endtask

  task automatic test_reset();
    user_reset_n = 1'b0;
    idle_all();
    #3;
    checks++; if (i128.s_axis_cc_tvalid !== 1'b0) $display("FAIL rst_tvalid128 got=%0b exp=0", i128.s_axis_cc_tvalid); else passes++;
    checks++; if (i128.s_axis_cc_tready_a !== 1'b0) $display("FAIL rst_tready_a128 got=%0b exp=0", i128.s_axis_cc_tready_a); else passes++;
    checks++; if (i64.s_axis_cc_tdata !== 64'h0) $display("FAIL rst_tdata64 got=%h exp=0", i64.s_axis_cc_tdata); else passes++;
    checks++; if (i512.s_axis_cc_tuser !== 81'h0) $display("FAIL rst_tuser512 got=%h exp=0", i512.s_axis_cc_tuser); else passes++;
    repeat (2) @(posedge user_clk);
    #2 user_reset_n = 1'b1;
    @(posedge user_clk); #1;
    checks++; if (i256.s_axis_cc_tready_a !== 1'b1) $display("FAIL post_rst_tready_a256 got=%0b exp=1", i256.s_axis_cc_tready_a); else passes++;
  endtask

  task automatic test_single_beat_128();
    i128.s_axis_cc_tdata_a  = {32'hDEADBEEF, 32'h00001234, 32'h01000004, 32'h4A000001};
    i128.s_axis_cc_tkeep_a  = 16'hFFFF;
    i128.s_axis_cc_tlast_a  = 1'b1;
    i128.s_axis_cc_tvalid_a = 1'b1;
    #1;
    checks++; if (i128.s_axis_cc_tready_a !== 1'b1) $display("FAIL t1_tready_a got=%0b exp=1", i128.s_axis_cc_tready_a); else passes++;
    @(posedge user_clk); #1;
    i128.s_axis_cc_tvalid_a = 1'b0;
    checks++; if (i128.s_axis_cc_tvalid !== 1'b1) $display("FAIL t1_tvalid got=%0b exp=1", i128.s_axis_cc_tvalid); else passes++;
    checks++; if (i128.s_axis_cc_tdata !== {32'hDEADBEEF, 32'h00010012, 32'h00000001, 32'h00040034})
      $display("FAIL t1_tdata got=%h exp=deadbeef000100120000000100040034", i128.s_axis_cc_tdata); else passes++;
    checks++; if (i128.s_axis_cc_tkeep !== 4'hF) $display("FAIL t1_tkeep got=%h exp=f", i128.s_axis_cc_tkeep); else passes++;
    checks++; if (i128.s_axis_cc_tlast !== 1'b1) $display("FAIL t1_tlast got=%0b exp=1", i128.s_axis_cc_tlast); else passes++;
    checks++; if (i128.s_axis_cc_tuser !== 33'h0) $display("FAIL t1_tuser got=%h exp=0", i128.s_axis_cc_tuser); else passes++;
    @(posedge user_clk); #1;
    checks++; if (i128.s_axis_cc_tvalid !== 1'b0) $display("FAIL t1_drain got=%0b exp=0", i128.s_axis_cc_tvalid); else passes++;
  endtask

  task automatic test_back_to_back_128();
    i128.s_axis_cc_tdata_a  = {32'hDEADBEEF, 32'h00001234, 32'h01000004, 32'h4A000005};
    i128.s_axis_cc_tkeep_a  = 16'hFFFF;
    i128.s_axis_cc_tlast_a  = 1'b0;
    i128.s_axis_cc_tvalid_a = 1'b1;
    @(posedge user_clk); #1;
    checks++; if (i128.s_axis_cc_tdata !== {32'hDEADBEEF, 32'h00010012, 32'h00000005, 32'h00040034})
      $display("FAIL b2b_hdr got=%h exp=deadbeef000100120000000500040034", i128.s_axis_cc_tdata); else passes++;
    checks++; if (i128.s_axis_cc_tlast !== 1'b0) $display("FAIL b2b_hdr_tlast got=%0b exp=0", i128.s_axis_cc_tlast); else passes++;
    i128.s_axis_cc_tdata_a = 128'h0123456789ABCDEFFEDCBA9876543210;
    i128.s_axis_cc_tkeep_a = 16'h00F1;
    i128.s_axis_cc_tlast_a = 1'b1;
    i128.s_axis_cc_tuser_a = 4'b1000;
    #1;
    checks++; if (i128.s_axis_cc_tready_a !== 1'b1) $display("FAIL b2b_no_bubble got=%0b exp=1", i128.s_axis_cc_tready_a); else passes++;
    @(posedge user_clk); #1;
    checks++; if (i128.s_axis_cc_tdata !== 128'h0123456789ABCDEFFEDCBA9876543210)
      $display("FAIL b2b_body got=%h exp=0123456789abcdeffedcba9876543210", i128.s_axis_cc_tdata); else passes++;
    checks++; if (i128.s_axis_cc_tkeep !== 4'b0011) $display("FAIL b2b_keep got=%b exp=0011", i128.s_axis_cc_tkeep); else passes++;
    checks++; if (i128.s_axis_cc_tuser !== 33'h1) $display("FAIL b2b_discont got=%h exp=1", i128.s_axis_cc_tuser); else passes++;
    i128.s_axis_cc_tdata_a = {32'hDEADBEEF, 32'h00001234, 32'h01000004, 32'h4A000001};
    i128.s_axis_cc_tkeep_a = 16'hFFFF;
    i128.s_axis_cc_tuser_a = 4'b0000;
    @(posedge user_clk); #1;
    i128.s_axis_cc_tvalid_a = 1'b0;
    checks++; if (i128.s_axis_cc_tdata !== {32'hDEADBEEF, 32'h00010012, 32'h00000001, 32'h00040034})
      $display("FAIL b2b_next_hdr got=%h exp=deadbeef000100120000000100040034", i128.s_axis_cc_tdata); else passes++;
    @(posedge user_clk); #1;
  endtask

  task automatic test_stall_256();
    logic [255:0] beat [2];
    logic [31:0]  bkeep [2];
    logic [255:0] got [4];
    logic         gl [4];
    logic [255:0] prev_d;
    logic         prev_stall, in_acc, out_acc;
    int           in_idx, out_cnt, stall_bad;
    beat[0]  = {32'h55550004, 32'h55550003, 32'h55550002, 32'h55550001, 32'h55550000,
                32'h00001234, 32'h01000020, 32'h4A000008};
    beat[1]  = {160'h0, 32'h55550007, 32'h55550006, 32'h55550005};
    bkeep[0] = 32'hFFFFFFFF;
    bkeep[1] = 32'h00000FFF;
    for (int k = 0; k < 4; k++) begin got[k] = '0; gl[k] = 1'b0; end
    in_idx = 0; out_cnt = 0; stall_bad = 0; prev_stall = 1'b0; prev_d = '0;
    for (int c = 0; c < 12; c++) begin
      i256.s_axis_cc_tready = (c % 2 == 0) ? 4'hF : 4'hE;
      if (in_idx < 2) begin
        i256.s_axis_cc_tvalid_a = 1'b1;
        i256.s_axis_cc_tdata_a  = beat[in_idx];
        i256.s_axis_cc_tkeep_a  = bkeep[in_idx];
        i256.s_axis_cc_tlast_a  = (in_idx == 1);
      end else begin
        i256.s_axis_cc_tvalid_a = 1'b0;
      end
      #1;
      if (prev_stall && i256.s_axis_cc_tdata !== prev_d) stall_bad++;
      in_acc  = i256.s_axis_cc_tvalid_a && i256.s_axis_cc_tready_a;
      out_acc = i256.s_axis_cc_tvalid && i256.s_axis_cc_tready[0];
      if (out_acc) begin
        if (out_cnt < 4) begin got[out_cnt] = i256.s_axis_cc_tdata; gl[out_cnt] = i256.s_axis_cc_tlast; end
        out_cnt++;
      end
      prev_stall = i256.s_axis_cc_tvalid && !i256.s_axis_cc_tready[0];
      prev_d     = i256.s_axis_cc_tdata;
      @(posedge user_clk); #1;
      if (in_acc) in_idx++;
    end
    i256.s_axis_cc_tready = 4'hF;
    checks++; if (out_cnt !== 2) $display("FAIL t2_beat_count got=%0d exp=2", out_cnt); else passes++;
    checks++; if (got[0] !== {beat[0][255:96], 32'h00010012, 32'h00000008, 32'h00200034})
      $display("FAIL t2_beat0 got=%h", got[0]); else passes++;
    checks++; if (got[1] !== beat[1]) $display("FAIL t2_beat1 got=%h exp=%h", got[1], beat[1]); else passes++;
    checks++; if (gl[0] !== 1'b0) $display("FAIL t2_tlast0 got=%0b exp=0", gl[0]); else passes++;
    checks++; if (gl[1] !== 1'b1) $display("FAIL t2_tlast1 got=%0b exp=1", gl[1]); else passes++;
    checks++; if (stall_bad !== 0) $display("FAIL t2_stall_hold got=%0d changes exp=0", stall_bad); else passes++;
  endtask

  task automatic test_split_header_64();
    i64.s_axis_cc_tdata_a  = 64'h01000004_4A000001;
    i64.s_axis_cc_tkeep_a  = 8'hFF;
    i64.s_axis_cc_tlast_a  = 1'b0;
    i64.s_axis_cc_tvalid_a = 1'b1;
    @(posedge user_clk); #1;
    checks++; if (i64.s_axis_cc_tvalid !== 1'b0) $display("FAIL t3_no_out_beat0 got=%0b exp=0", i64.s_axis_cc_tvalid); else passes++;
    i64.s_axis_cc_tdata_a = 64'hDEADBEEF_00001234;
    i64.s_axis_cc_tlast_a = 1'b1;
    @(posedge user_clk); #1;
    i64.s_axis_cc_tvalid_a = 1'b0;
    checks++; if (i64.s_axis_cc_tdata !== 64'h00000001_00040034) $display("FAIL t3_d1d0 got=%h exp=0000000100040034", i64.s_axis_cc_tdata); else passes++;
    checks++; if (i64.s_axis_cc_tkeep !== 2'b11) $display("FAIL t3_keep0 got=%b exp=11", i64.s_axis_cc_tkeep); else passes++;
    checks++; if (i64.s_axis_cc_tlast !== 1'b0) $display("FAIL t3_tlast0 got=%0b exp=0", i64.s_axis_cc_tlast); else passes++;
    checks++; if (i64.s_axis_cc_tready_a !== 1'b0) $display("FAIL t3_flush_bubble got=%0b exp=0", i64.s_axis_cc_tready_a); else passes++;
    @(posedge user_clk); #1;
    checks++; if (i64.s_axis_cc_tdata !== 64'hDEADBEEF_00010012) $display("FAIL t3_p0d2 got=%h exp=deadbeef00010012", i64.s_axis_cc_tdata); else passes++;
    checks++; if (i64.s_axis_cc_tlast !== 1'b1) $display("FAIL t3_tlast1 got=%0b exp=1", i64.s_axis_cc_tlast); else passes++;
    checks++; if (i64.s_axis_cc_tready_a !== 1'b1) $display("FAIL t3_bubble_end got=%0b exp=1", i64.s_axis_cc_tready_a); else passes++;
    @(posedge user_clk); #1;
  endtask

  task automatic test_truncated_64();
    i64.s_axis_cc_tdata_a  = 64'h01000004_4A000001;
    i64.s_axis_cc_tkeep_a  = 8'hFF;
    i64.s_axis_cc_tlast_a  = 1'b1;
    i64.s_axis_cc_tvalid_a = 1'b1;
    @(posedge user_clk); #1;
    i64.s_axis_cc_tvalid_a = 1'b0;
    checks++; if (i64.s_axis_cc_tvalid !== 1'b1) $display("FAIL t4_tvalid got=%0b exp=1", i64.s_axis_cc_tvalid); else passes++;
    checks++; if (i64.s_axis_cc_tdata !== 64'h0) $display("FAIL t4_tdata got=%h exp=0", i64.s_axis_cc_tdata); else passes++;
    checks++; if (i64.s_axis_cc_tkeep !== 2'b00) $display("FAIL t4_keep got=%b exp=00", i64.s_axis_cc_tkeep); else passes++;
    checks++; if (i64.s_axis_cc_tlast !== 1'b1) $display("FAIL t4_tlast got=%0b exp=1", i64.s_axis_cc_tlast); else passes++;
    checks++; if (i64.s_axis_cc_tuser !== 33'h1) $display("FAIL t4_discont got=%h exp=1", i64.s_axis_cc_tuser); else passes++;
    @(posedge user_clk); #1;
    checks++; if (i64.s_axis_cc_tvalid !== 1'b0) $display("FAIL t4_single_beat got=%0b exp=0", i64.s_axis_cc_tvalid); else passes++;
    i64.s_axis_cc_tdata_a  = 64'h01000004_4A000001;
    i64.s_axis_cc_tlast_a  = 1'b0;
    i64.s_axis_cc_tvalid_a = 1'b1;
    @(posedge user_clk); #1;
    i64.s_axis_cc_tdata_a = 64'hCAFEF00D_00001234;
    i64.s_axis_cc_tkeep_a = 8'h0F;
    i64.s_axis_cc_tlast_a = 1'b1;
    @(posedge user_clk); #1;
    i64.s_axis_cc_tvalid_a = 1'b0;
    checks++; if (i64.s_axis_cc_tdata !== 64'h00000001_00040034) $display("FAIL t4_next_d1d0 got=%h exp=0000000100040034", i64.s_axis_cc_tdata); else passes++;
    checks++; if (i64.s_axis_cc_tuser !== 33'h0) $display("FAIL t4_next_tuser got=%h exp=0", i64.s_axis_cc_tuser); else passes++;
    @(posedge user_clk); #1;
    checks++; if (i64.s_axis_cc_tdata !== 64'hCAFEF00D_00010012) $display("FAIL t4_next_p0d2 got=%h exp=cafef00d00010012", i64.s_axis_cc_tdata); else passes++;
    checks++; if (i64.s_axis_cc_tkeep !== 2'b01) $display("FAIL t4_next_keep got=%b exp=01", i64.s_axis_cc_tkeep); else passes++;
    @(posedge user_clk); #1;
  endtask

  task automatic test_lock_ecrc_512();
    logic [511:0] d, e;
    d = '0; d[31:0] = 32'h4B000001; d[63:32] = 32'h01000004; d[95:64] = 32'h00001234; d[127:96] = 32'hA5A5A5A5;
    e = '0; e[31:0] = 32'h20040034; e[63:32] = 32'h00000001; e[95:64] = 32'h80010012; e[127:96] = 32'hA5A5A5A5;
    i512.s_axis_cc_tdata_a  = d;
    i512.s_axis_cc_tkeep_a  = 64'hFFFF;
    i512.s_axis_cc_tlast_a  = 1'b0;
    i512.s_axis_cc_tuser_a  = 4'b0001;
    i512.s_axis_cc_tvalid_a = 1'b1;
    @(posedge user_clk); #1;
    i512.s_axis_cc_tvalid_a = 1'b0;
    i512.s_axis_cc_tuser_a  = 4'b0000;
    i512.s_axis_cc_tready   = 4'h0;
    checks++; if (i512.s_axis_cc_tdata !== e) $display("FAIL t5_tdata got=%h", i512.s_axis_cc_tdata[127:0]); else passes++;
    checks++; if (i512.s_axis_cc_tdata[29] !== 1'b1) $display("FAIL t5_lock_bit got=%0b exp=1", i512.s_axis_cc_tdata[29]); else passes++;
    checks++; if (i512.s_axis_cc_tdata[95] !== 1'b1) $display("FAIL t5_ecrc_bit got=%0b exp=1", i512.s_axis_cc_tdata[95]); else passes++;
    checks++; if (i512.s_axis_cc_tuser !== 81'h0) $display("FAIL t5_tuser got=%h exp=0", i512.s_axis_cc_tuser); else passes++;
    checks++; if (i512.s_axis_cc_tkeep !== 16'h000F) $display("FAIL t5_keep got=%h exp=000f", i512.s_axis_cc_tkeep); else passes++;
  endtask

  task automatic test_reset_mid_packet_512();
    logic [511:0] d, e;
    @(posedge user_clk); #1;
    checks++; if (i512.s_axis_cc_tvalid !== 1'b1) $display("FAIL t6_held got=%0b exp=1", i512.s_axis_cc_tvalid); else passes++;
    #2 user_reset_n = 1'b0;
    #1;
    checks++; if (i512.s_axis_cc_tvalid !== 1'b0) $display("FAIL t6_async_tvalid got=%0b exp=0", i512.s_axis_cc_tvalid); else passes++;
    checks++; if (i512.s_axis_cc_tdata !== 512'h0) $display("FAIL t6_async_tdata got=%h", i512.s_axis_cc_tdata[127:0]); else passes++;
    checks++; if (i512.s_axis_cc_tkeep !== 16'h0) $display("FAIL t6_async_tkeep got=%h exp=0", i512.s_axis_cc_tkeep); else passes++;
    checks++; if (i512.s_axis_cc_tready_a !== 1'b0) $display("FAIL t6_async_tready_a got=%0b exp=0", i512.s_axis_cc_tready_a); else passes++;
    @(posedge user_clk); #1;
    user_reset_n = 1'b1;
    i512.s_axis_cc_tready = 4'hF;
    d = '0; d[31:0] = 32'h4A000001; d[63:32] = 32'h01000004; d[95:64] = 32'h00001234; d[127:96] = 32'hA5A5A5A5;
    e = '0; e[31:0] = 32'h00040034; e[63:32] = 32'h00000001; e[95:64] = 32'h00010012; e[127:96] = 32'hA5A5A5A5;
    i512.s_axis_cc_tdata_a  = d;
    i512.s_axis_cc_tkeep_a  = 64'hFFFF;
    i512.s_axis_cc_tlast_a  = 1'b1;
    i512.s_axis_cc_tvalid_a = 1'b1;
    @(posedge user_clk); #1;
    i512.s_axis_cc_tvalid_a = 1'b0;
    checks++; if (i512.s_axis_cc_tdata !== e) $display("FAIL t6_post_hdr got=%h", i512.s_axis_cc_tdata[127:0]); else passes++;
    checks++; if (i512.s_axis_cc_tlast !== 1'b1) $display("FAIL t6_post_tlast got=%0b exp=1", i512.s_axis_cc_tlast); else passes++;
  endtask

  initial begin
    test_reset();
    test_single_beat_128();
    test_back_to_back_128();
    test_stall_256();
    test_split_header_64();
    test_truncated_64();
    test_lock_ecrc_512();
    test_reset_mid_packet_512();
    repeat (2) @(posedge user_clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
